// File: rtl/video_pixel_fetch_if.sv
// Video-memory read port: address and request out,
// data and one-cycle done pulse back.
interface video_pixel_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_q;
  logic [DATA_W-1:0] mem_data;
  logic              mem_read_dn;

  modport master (
    output mem_addr, mem_read_q,
    input  mem_data, mem_read_dn
  );

  modport slave (
    input  mem_addr, mem_read_q,
    output mem_data, mem_read_dn
  );
endinterface

// File: rtl/video_pixel_fetch.sv
// Display prefetcher: fetches pixel words from video SRAM into a
// FIFO and emits 4-bit RGB aligned with the delayed de/hs/vs.
module video_pixel_fetch #(
  parameter int FB_BASE   = 0,
  parameter int FB_PIXELS = 307200,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                de_i,
  input  logic                hs_i,
  input  logic                vs_i,
  video_pixel_fetch_if.master mem,
  output logic [3:0]          r_o,
  output logic [3:0]          g_o,
  output logic [3:0]          b_o,
  output logic                de_o,
  output logic                hs_o,
  output logic                vs_o,
  output logic                underflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_BASE + FB_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DROP
  } state_t;

  state_t            state_q;
  logic [11:0]       buf_q [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q;
  logic              vs_prev_q;
  logic              fs;
  logic              push;
  logic              pop;
  logic              empty;

  assign mem.mem_addr   = addr_q;
  assign mem.mem_read_q = read_q;

  always_comb begin
    fs    = vs_prev_q & ~vs_i;
    empty = (cnt_q == '0);
    push  = (state_q == READ) &&
            mem.mem_read_dn && !fs;
    pop   = de_i && !empty && !fs;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ptr_d = (ptr_q == LAST) ? BASE
          : ptr_q + ADDR_W'(1);
  end

  // Only the three colour nibbles are kept per entry.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_q] <= {mem.mem_data[19:16],
                      mem.mem_data[11:8],
                      mem.mem_data[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (fs) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // A request caught by frame start is completed in DROP and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      addr_q  <= BASE;
      ptr_q   <= BASE;
    end else begin
      if (fs)        ptr_q <= BASE;
      else if (push) ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (!fs && cnt_q < CW'(DEPTH)) begin
            read_q  <= 1'b1;
            addr_q  <= ptr_q;
            state_q <= READ;
          end
        end
        READ: begin
          if (mem.mem_read_dn) begin
            read_q  <= 1'b0;
            state_q <= IDLE;
          end else if (fs) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (mem.mem_read_dn) begin
            read_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          read_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b1;
      de_o        <= 1'b0;
      hs_o        <= 1'b1;
      vs_o        <= 1'b1;
      r_o         <= '0;
      g_o         <= '0;
      b_o         <= '0;
      underflow_o <= 1'b0;
    end else begin
      vs_prev_q <= vs_i;
      de_o      <= de_i;
      hs_o      <= hs_i;
      vs_o      <= vs_i;
      if (pop) begin
        {b_o, g_o, r_o} <= buf_q[rd_q];
      end else begin
        {b_o, g_o, r_o} <= '0;
      end
      if (fs)                 underflow_o <= 1'b0;
      else if (de_i && empty) underflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_video_pixel_fetch.sv
// Directed bench for video_pixel_fetch with a simple
// variable-latency video-memory model per instance.
module tb_video_pixel_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic de1 = 1'b0, hs1 = 1'b1, vs1 = 1'b1;
  logic de2 = 1'b0, hs2 = 1'b1, vs2 = 1'b1;
  logic [3:0] r1, g1, b1, r2, g2, b2;
  logic deo1, hso1, vso1, uf1;
  logic deo2, hso2, vso2, uf2;

  video_pixel_fetch_if #(32, 32) m1 ();
  video_pixel_fetch_if #(32, 32) m2 ();

  video_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .de_i(de1), .hs_i(hs1), .vs_i(vs1),
    .mem(m1),
    .r_o(r1), .g_o(g1), .b_o(b1),
    .de_o(deo1), .hs_o(hso1), .vs_o(vso1),
    .underflow_o(uf1)
  );

  video_pixel_fetch #(
    .FB_BASE(0), .FB_PIXELS(4), .DEPTH(4)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .de_i(de2), .hs_i(hs2), .vs_i(vs2),
    .mem(m2),
    .r_o(r2), .g_o(g2), .b_o(b2),
    .de_o(deo2), .hs_o(hso2), .vs_o(vso2),
    .underflow_o(uf2)
  );

  function automatic logic [31:0] memword(
    input logic [31:0] a);
    return a | 32'h0005_0A03;
  endfunction

  int lat1 = 0, w1 = 0;
  logic dn1 = 1'b0, dn_force = 1'b0;
  logic [31:0] data1 = '0;
  logic [31:0] log1 [$];
  assign m1.mem_read_dn = dn1 | dn_force;
  assign m1.mem_data = data1;

  always @(negedge clk) begin
    if (!m1.mem_read_q) begin
      w1 <= 0;
      dn1 <= 1'b0;
    end else if (dn1) begin
      dn1 <= 1'b0;
    end else if (w1 >= lat1) begin
      dn1 <= 1'b1;
      data1 <= memword(m1.mem_addr);
      log1.push_back(m1.mem_addr);
      w1 <= 0;
    end else begin
      w1 <= w1 + 1;
    end
  end

  logic dn2 = 1'b0;
  logic [31:0] data2 = '0;
  logic [31:0] log2 [$];
  assign m2.mem_read_dn = dn2;
  assign m2.mem_data = data2;

  always @(negedge clk) begin
    if (!m2.mem_read_q) begin
      dn2 <= 1'b0;
    end else if (dn2) begin
      dn2 <= 1'b0;
    end else begin
      dn2 <= 1'b1;
      data2 <= memword(m2.mem_addr);
      log2.push_back(m2.mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fs1();
    vs1 = 1'b0;
    tick();
    vs1 = 1'b1;
  endtask

  task automatic wait_rd1(input logic lvl,
                          input string nm);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (m1.mem_read_q === lvl) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, mem_read_q never %0b",
               nm, lvl);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    de1 = 1'b1;
    hs1 = 1'b0;
    vs1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dn_force = i[0];
      tick();
    end
    checks++;
    if (m1.mem_read_q !== 1'b0) begin
      errors++;
      $display("FAIL rst_read: got %b want 0",
               m1.mem_read_q);
    end
    checks++;
    if (hso1 !== 1'b1 || vso1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_sync: hs=%b vs=%b want 1 1",
               hso1, vso1);
    end
    checks++;
    if (deo1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_de: got %b want 0", deo1);
    end
    checks++;
    if ({r1, g1, b1} !== 12'h000) begin
      errors++;
      $display("FAIL rst_rgb: got %h want 000",
               {r1, g1, b1});
    end
    checks++;
    if (uf1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_uf: got %b want 0", uf1);
    end
    dn_force = 1'b0;
    de1 = 1'b0;
    hs1 = 1'b1;
    vs1 = 1'b1;
    tick();
    rst_n = 1'b1;
    wait_rd1(1'b1, "rst_first_req");
    checks++;
    if (m1.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_addr: got %0d want 0",
               m1.mem_addr);
    end
  endtask

  task automatic test_fill_read();
    logic [31:0] w;
    int bad;
    lat1 = 0;
    fs1();
    log1.delete();
    repeat (40) tick();
    for (int i = 0; i < 20; i++) begin
      de1 = 1'b1;
      tick();
      w = memword(i);
      if (i == 0) begin
        checks++;
        if (r1 !== 4'h3 || g1 !== 4'hA ||
            b1 !== 4'h5) begin
          errors++;
          $display("FAIL first_pixel: rgb=%h%h%h want 3A5",
                   r1, g1, b1);
        end
        checks++;
        if (deo1 !== 1'b1) begin
          errors++;
          $display("FAIL first_de: got %b want 1", deo1);
        end
      end else begin
        checks++;
        if (r1 !== w[3:0] || g1 !== w[11:8] ||
            b1 !== w[19:16]) begin
          errors++;
          $display("FAIL pixel_%0d: rgb=%h%h%h want %h%h%h",
                   i, r1, g1, b1,
                   w[3:0], w[11:8], w[19:16]);
        end
      end
    end
    de1 = 1'b0;
    tick();
    checks++;
    if ({r1, g1, b1} !== 12'h000) begin
      errors++;
      $display("FAIL blank_rgb: got %h want 000",
               {r1, g1, b1});
    end
    checks++;
    if (uf1 !== 1'b0) begin
      errors++;
      $display("FAIL fill_uf: got %b want 0", uf1);
    end
    bad = -1;
    foreach (log1[i]) begin
      if (bad < 0 && log1[i] !== 32'(i)) bad = i;
    end
    checks++;
    if (bad >= 0 || log1.size() < 20) begin
      errors++;
      $display("FAIL fill_addr: n=%0d first_bad=%0d want seq 0..",
               log1.size(), bad);
    end
  endtask

  task automatic test_wrap();
    int bad;
    vs2 = 1'b0;
    tick();
    vs2 = 1'b1;
    log2.delete();
    de2 = 1'b1;
    repeat (30) tick();
    de2 = 1'b0;
    bad = -1;
    foreach (log2[i]) begin
      if (bad < 0 && log2[i] !== 32'(i % 4)) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL wrap_addr: idx %0d got %0d want %0d",
               bad, log2[bad], bad % 4);
    end
    checks++;
    if (log2.size() < 8) begin
      errors++;
      $display("FAIL wrap_count: got %0d want >=8",
               log2.size());
    end
  endtask

  task automatic test_underflow();
    lat1 = 8;
    de1 = 1'b0;
    fs1();
    de1 = 1'b1;
    tick();
    checks++;
    if (uf1 !== 1'b1) begin
      errors++;
      $display("FAIL uf_set: got %b want 1", uf1);
    end
    checks++;
    if ({r1, g1, b1} !== 12'h000 || deo1 !== 1'b1) begin
      errors++;
      $display("FAIL uf_rgb: rgb=%h de=%b want 000 1",
               {r1, g1, b1}, deo1);
    end
    repeat (5) tick();
    de1 = 1'b0;
    repeat (3) tick();
    checks++;
    if (uf1 !== 1'b1) begin
      errors++;
      $display("FAIL uf_sticky: got %b want 1", uf1);
    end
    fs1();
    checks++;
    if (uf1 !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: got %b want 0", uf1);
    end
  endtask

  task automatic test_fs_during_read();
    bit ok = 0;
    lat1 = 5;
    de1 = 1'b0;
    wait_rd1(1'b0, "fsr_idle");
    fs1();
    log1.delete();
    for (int i = 0; i < 300; i++) begin
      if (log1.size() >= 4) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fsr_fill: timeout, got %0d words",
               log1.size());
    end
    wait_rd1(1'b0, "fsr_gap");
    wait_rd1(1'b1, "fsr_req");
    checks++;
    if (m1.mem_addr !== 32'd4) begin
      errors++;
      $display("FAIL fsr_addr4: got %0d want 4",
               m1.mem_addr);
    end
    tick();
    fs1();
    checks++;
    if (m1.mem_read_q !== 1'b1) begin
      errors++;
      $display("FAIL fsr_hold: read=%b want 1",
               m1.mem_read_q);
    end
    de1 = 1'b1;
    tick();
    de1 = 1'b0;
    checks++;
    if (uf1 !== 1'b1 || {r1, g1, b1} !== 12'h000) begin
      errors++;
      $display("FAIL fsr_empty: uf=%b rgb=%h want 1 000",
               uf1, {r1, g1, b1});
    end
    wait_rd1(1'b0, "fsr_drop");
    wait_rd1(1'b1, "fsr_next");
    checks++;
    if (m1.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL fsr_base: got %0d want 0",
               m1.mem_addr);
    end
    wait_rd1(1'b0, "fsr_done");
    repeat (2) tick();
    de1 = 1'b1;
    tick();
    de1 = 1'b0;
    checks++;
    if (r1 !== 4'h3 || g1 !== 4'hA || b1 !== 4'h5) begin
      errors++;
      $display("FAIL fsr_pixel: rgb=%h%h%h want 3A5",
               r1, g1, b1);
    end
  endtask

  task automatic test_sync_delay();
    logic [7:0] hp;
    logic [7:0] vp;
    logic ph, pv;
    hp = 8'b1011_0010;
    vp = 8'b1100_1101;
    de1 = 1'b0;
    hs1 = 1'b1;
    vs1 = 1'b1;
    tick();
    ph = 1'b1;
    pv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hs1 = hp[i];
      vs1 = vp[i];
      #1;
      checks++;
      if (hso1 !== ph || vso1 !== pv) begin
        errors++;
        $display("FAIL sync_%0d: hs=%b vs=%b want %b %b",
                 i, hso1, vso1, ph, pv);
      end
      checks++;
      if ({r1, g1, b1} !== 12'h000 || deo1 !== 1'b0) begin
        errors++;
        $display("FAIL sync_blank_%0d: rgb=%h de=%b want 000 0",
                 i, {r1, g1, b1}, deo1);
      end
      tick();
      ph = hp[i];
      pv = vp[i];
    end
    hs1 = 1'b1;
    vs1 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_read();
    test_wrap();
    test_underflow();
    test_fs_during_read();
    test_sync_delay();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
